// File: rtl/antirrebote_multi.sv
// antirrebote_multi: N-channel 2-FF synchroniser and stability-counter debouncer with edge strobes.
// Optional long-press detector compiled in by defining ANTIRREBOTE_PULSACION_LARGA_EN.
module antirrebote_multi #(
    parameter int unsigned N_CANALES      = 4,
    parameter int unsigned CICLOS_ESTABLE = 250000,
    parameter int unsigned CICLOS_LARGO   = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CANALES-1:0] btn,
    output logic [N_CANALES-1:0] clean,
    output logic [N_CANALES-1:0] sube,
    output logic [N_CANALES-1:0] baja,
    output logic [N_CANALES-1:0] largo
);

    localparam int unsigned CICLOS_MAX = (CICLOS_ESTABLE > CICLOS_LARGO) ? CICLOS_ESTABLE : CICLOS_LARGO;
    localparam int unsigned ANCHO_CNT  = $clog2(CICLOS_MAX + 1);
    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(CICLOS_ESTABLE - 1);

    logic [N_CANALES-1:0] s1;
    logic [N_CANALES-1:0] s2;
    logic [ANCHO_CNT-1:0] cnt [N_CANALES];

    // Synchroniser, stability counter and edge strobes; any agreement between s2 and clean restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            clean <= '0;
            sube  <= '0;
            baja  <= '0;
            for (int unsigned i = 0; i < N_CANALES; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= btn;
            s2 <= s1;
            for (int unsigned i = 0; i < N_CANALES; i++) begin
                sube[i] <= 1'b0;
                baja[i] <= 1'b0;
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_FIN) begin
                    clean[i] <= s2[i];
                    sube[i]  <= s2[i];
                    baja[i]  <= ~s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + ANCHO_CNT'(1);
                end
            end
        end
    end

`ifdef ANTIRREBOTE_PULSACION_LARGA_EN
    localparam logic [ANCHO_CNT-1:0] LARGO_FIN = ANCHO_CNT'(CICLOS_LARGO);
    localparam logic [ANCHO_CNT-1:0] LARGO_PRE = ANCHO_CNT'(CICLOS_LARGO - 1);

    logic [ANCHO_CNT-1:0] cnt_largo [N_CANALES];

    // Saturating hold-time counter; saturation keeps largo to one pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            largo <= '0;
            for (int unsigned i = 0; i < N_CANALES; i++) begin
                cnt_largo[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CANALES; i++) begin
                largo[i] <= 1'b0;
                if (!clean[i]) begin
                    cnt_largo[i] <= '0;
                end else if (cnt_largo[i] != LARGO_FIN) begin
                    cnt_largo[i] <= cnt_largo[i] + ANCHO_CNT'(1);
                    largo[i]     <= (cnt_largo[i] == LARGO_PRE);
                end
            end
        end
    end
`else
    assign largo = '0;
`endif

endmodule
